// File: rtl/rr_onehot_arbiter.sv
// rr_onehot_arbiter: N-channel round-robin arbiter with a locked grant
// and a one-hot data mux toward a single shared consumer.
module rr_onehot_arbiter #(
  parameter int NUM_CH = 4,
  parameter int SIZE   = 32,
  parameter int IDX_W  = 2
) (
  input  logic                   Clock,
  input  logic                   Reset,
  input  logic                   iEnable,
  input  logic [NUM_CH-1:0]      iRequest,
  input  logic [NUM_CH*SIZE-1:0] iData,
  input  logic                   iRelease,
  output logic [NUM_CH-1:0]      oGrant,
  output logic [IDX_W-1:0]       oGrantIndex,
  output logic                   oValid,
  output logic [SIZE-1:0]        oData
);

  typedef enum logic {
    IDLE,
    GRANTED
  } state_t;

  state_t            state_q;
  state_t            state_d;
  logic [NUM_CH-1:0] ptr_q;
  logic [NUM_CH-1:0] ptr_d;
  logic [NUM_CH-1:0] grant_d;
  logic [IDX_W-1:0]  idx_d;
  logic              valid_d;

  logic [NUM_CH-1:0] ptr_rot;
  logic [NUM_CH-1:0] others;
  logic [NUM_CH-1:0] req_rel;
  logic [NUM_CH-1:0] cand_idle;
  logic [NUM_CH-1:0] cand_rel;

  // First requester at or above the one-hot pointer, wrapping to ch0.
  function automatic logic [NUM_CH-1:0] pick(
    input logic [NUM_CH-1:0] req,
    input logic [NUM_CH-1:0] ptr
  );
    logic [NUM_CH-1:0] res;
    logic              found;
    int                j;
    res   = '0;
    found = 1'b0;
    for (int s = 0; s < NUM_CH; s++) begin
      if (ptr[s]) begin
        for (int k = 0; k < NUM_CH; k++) begin
          j = (s + k) % NUM_CH;
          if (!found && req[j]) begin
            res[j] = 1'b1;
            found  = 1'b1;
          end
        end
      end
    end
    return res;
  endfunction

  // Binary index of a one-hot vector (zero when the vector is zero).
  function automatic logic [IDX_W-1:0] to_idx(
    input logic [NUM_CH-1:0] oh
  );
    logic [IDX_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (oh[i]) begin
        idx = idx | IDX_W'(i);
      end
    end
    return idx;
  endfunction

  // Candidate grants for the idle search and the release re-arbitration.
  always_comb begin
    ptr_rot   = {oGrant[NUM_CH-2:0], oGrant[NUM_CH-1]};
    others    = iRequest & ~oGrant;
    req_rel   = (|others) ? others : iRequest;
    cand_idle = pick(iRequest, ptr_q);
    cand_rel  = pick(req_rel, ptr_rot);
  end

  // Next-state, next-pointer and next-grant selection.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    grant_d = oGrant;
    idx_d   = oGrantIndex;
    valid_d = oValid;
    unique case (state_q)
      IDLE: begin
        if (iEnable && (|cand_idle)) begin
          grant_d = cand_idle;
          idx_d   = to_idx(cand_idle);
          valid_d = 1'b1;
          state_d = GRANTED;
        end else begin
          grant_d = '0;
          idx_d   = '0;
          valid_d = 1'b0;
        end
      end
      GRANTED: begin
        if (iRelease) begin
          ptr_d = ptr_rot;
          if (iEnable && (|cand_rel)) begin
            grant_d = cand_rel;
            idx_d   = to_idx(cand_rel);
            valid_d = 1'b1;
          end else begin
            grant_d = '0;
            idx_d   = '0;
            valid_d = 1'b0;
            state_d = IDLE;
          end
        end
      end
      default: begin
        grant_d = '0;
        idx_d   = '0;
        valid_d = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  // State, pointer and registered grant outputs.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q     <= IDLE;
      ptr_q       <= NUM_CH'(1);
      oGrant      <= '0;
      oGrantIndex <= '0;
      oValid      <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      oGrant      <= grant_d;
      oGrantIndex <= idx_d;
      oValid      <= valid_d;
    end
  end

  // AND-OR mux of the granted channel's data; zero with no grant.
  always_comb begin
    oData = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (oGrant[k]) begin
        oData = oData | iData[k*SIZE +: SIZE];
      end
    end
  end

  a_grant_onehot0 : assert property (
    @(posedge Clock) disable iff (Reset) $onehot0(oGrant));

  a_valid_match : assert property (
    @(posedge Clock) disable iff (Reset) oValid == (|oGrant));

  a_idx_match : assert property (
    @(posedge Clock) disable iff (Reset)
    oValid |-> (oGrant[oGrantIndex] == 1'b1));

  a_ptr_onehot : assert property (
    @(posedge Clock) disable iff (Reset) $onehot(ptr_q));

  a_idx_width : assert property (
    @(posedge Clock) IDX_W == $clog2(NUM_CH));

endmodule

// File: tb/tb_rr_onehot_arbiter.sv
// tb_rr_onehot_arbiter: directed checks of grant order, locking,
// wrap-around, enable gating and asynchronous reset.
module tb_rr_onehot_arbiter;

  localparam int NUM_CH = 4;
  localparam int SIZE   = 32;
  localparam int IDX_W  = 2;

  logic                   Clock;
  logic                   Reset;
  logic                   iEnable;
  logic [NUM_CH-1:0]      iRequest;
  logic [NUM_CH*SIZE-1:0] iData;
  logic                   iRelease;
  logic [NUM_CH-1:0]      oGrant;
  logic [IDX_W-1:0]       oGrantIndex;
  logic                   oValid;
  logic [SIZE-1:0]        oData;

  int n_checks;
  int n_fail;

  logic [SIZE-1:0] dat [NUM_CH];

  rr_onehot_arbiter #(
    .NUM_CH(NUM_CH),
    .SIZE  (SIZE),
    .IDX_W (IDX_W)
  ) dut (
    .Clock      (Clock),
    .Reset      (Reset),
    .iEnable    (iEnable),
    .iRequest   (iRequest),
    .iData      (iData),
    .iRelease   (iRelease),
    .oGrant     (oGrant),
    .oGrantIndex(oGrantIndex),
    .oValid     (oValid),
    .oData      (oData)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic chk(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic chk_grant(
    input string       tag,
    input int          ch
  );
    logic [NUM_CH-1:0] oh;
    oh = '0;
    oh[ch] = 1'b1;
    chk({tag, "_grant"}, 32'(oGrant), 32'(oh));
    chk({tag, "_idx"}, 32'(oGrantIndex), 32'(ch));
    chk({tag, "_valid"}, 32'(oValid), 32'd1);
    chk({tag, "_data"}, oData, dat[ch]);
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_grant"}, 32'(oGrant), 32'd0);
    chk({tag, "_valid"}, 32'(oValid), 32'd0);
    chk({tag, "_data"}, oData, 32'd0);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    dat[0] = 32'h1111_0000;
    dat[1] = 32'h2222_0001;
    dat[2] = 32'hDEAD_BEEF;
    dat[3] = 32'h4444_0003;
    for (int k = 0; k < NUM_CH; k++) begin
      iData[k*SIZE +: SIZE] = dat[k];
    end
    Reset    = 1'b1;
    iEnable  = 1'b0;
    iRequest = '0;
    iRelease = 1'b0;

    #12;
    chk_idle("reset");
    chk("reset_idx", 32'(oGrantIndex), 32'd0);
    Reset = 1'b0;
    tick();

    // Full request: 0,1,2,3,0 with a release every third cycle.
    iEnable  = 1'b1;
    iRequest = 4'b1111;
    tick();
    chk_grant("rr0", 0);
    for (int n = 1; n <= 4; n++) begin
      tick();
      chk("rr_hold", 32'(oGrant), 32'(4'b0001 << ((n - 1) % 4)));
      iRelease = 1'b1;
      tick();
      iRelease = 1'b0;
      chk_grant("rr_next", n % 4);
      tick();
    end
    iRequest = '0;
    iRelease = 1'b1;
    tick();
    iRelease = 1'b0;
    chk_idle("rr_end");

    // Lone ch2 request, grant held after request drops.
    iRequest = 4'b0100;
    tick();
    chk_grant("ch2", 2);
    iRequest = '0;
    tick();
    tick();
    chk_grant("ch2_lock", 2);
    iRelease = 1'b1;
    tick();
    iRelease = 1'b0;
    chk_idle("ch2_rel");

    // Pointer now at ch3: 0011 must wrap to ch0.
    iRequest = 4'b0011;
    tick();
    chk_grant("wrap", 0);
    iRequest = '0;
    iRelease = 1'b1;
    tick();
    iRelease = 1'b0;
    chk_idle("wrap_rel");

    // Single requester ch1 re-granted with no bubble.
    iRequest = 4'b0010;
    tick();
    chk_grant("solo", 1);
    for (int n = 0; n < 3; n++) begin
      iRelease = 1'b1;
      tick();
      chk_grant("solo_re", 1);
    end
    iRelease = 1'b0;
    iRequest = '0;
    iRelease = 1'b1;
    tick();
    iRelease = 1'b0;
    chk_idle("solo_end");

    // Enable gating; release in idle is ignored.
    iEnable  = 1'b0;
    iRequest = 4'b1000;
    for (int n = 0; n < 5; n++) begin
      iRelease = (n == 2);
      tick();
      chk("en_off_valid", 32'(oValid), 32'd0);
    end
    iRelease = 1'b0;
    iEnable  = 1'b1;
    tick();
    chk_grant("en_on", 3);

    // Enable dropped while granted: release goes idle.
    iEnable  = 1'b0;
    iRequest = 4'b1111;
    tick();
    chk_grant("en_hold", 3);
    iRelease = 1'b1;
    tick();
    iRelease = 1'b0;
    chk_idle("en_rel");

    // Async reset mid-grant.
    iEnable  = 1'b1;
    iRequest = 4'b0100;
    tick();
    chk_grant("pre_rst", 2);
    #3;
    Reset = 1'b1;
    #1;
    chk_idle("async_rst");
    #1;
    Reset    = 1'b0;
    iRequest = 4'b1111;
    tick();
    chk_grant("post_rst", 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/rr_onehot_arbiter.md
Name: rr_onehot_arbiter

Overview:
- Parametrised N-channel round-robin arbiter with a locked grant and a data mux.
- Generalises the walking-one circular shifter and the one-hot 3-input mux into a single sequential block:
  - a rotating one-hot priority pointer selects among NUM_CH requesters;
  - the grant stays locked until the consumer releases it;
  - the granted channel's data is muxed to one output.
- Sits between multiple producers (e.g. execution units, memory clients) and one shared resource.

Parameters:
- NUM_CH, 4, number of requesting channels (2..16).
- SIZE, 32, data width per channel.
- IDX_W, 2, width of the grant index; must equal clog2(NUM_CH).

Ports:
- Clock  in  1  system clock; all state changes on the rising edge.
- Reset  in  1  asynchronous, active-high reset.
- iEnable  in  1  when low, no new grant is issued; an existing grant is held and can still be released.
- iRequest  in  NUM_CH  per-channel request, level-sensitive.
- iData  in  NUM_CH*SIZE  channel k data occupies bits [k*SIZE +: SIZE].
- iRelease  in  1  consumer ends the current grant; sampled only in state GRANTED.
- oGrant  out  NUM_CH  one-hot grant, registered; all zero when idle.
- oGrantIndex  out  IDX_W  binary index of the granted channel, registered.
- oValid  out  1  high while a grant is active.
- oData  out  SIZE  iData slice of the granted channel (combinational from the registered grant); zero when oValid is low.

Behaviour:
- Reset:
  - Clock and reset are as stated: one clock; reset is asynchronous and active-high.
  - While Reset is high, immediately: oGrant=0, oGrantIndex=0, oValid=0, oData=0, pointer=1 (channel 0 has highest priority), state=IDLE.
- State IDLE:
  - If iEnable=1 and iRequest is not 0, pick the first requesting channel, searching upward from the pointer bit with wrap from NUM_CH-1 to 0.
  - On the next edge: oGrant=one-hot(pick), oGrantIndex=pick, oValid=1, state=GRANTED.
  - Latency from a request first sampled high to oValid is 1 cycle.
  - Otherwise remain in IDLE with all outputs zero.
- State GRANTED:
  - Grant is locked. Changes to iRequest, including the granted channel dropping its request, do not affect oGrant.
  - iRelease=0: hold all outputs.
  - iRelease=1: the pointer becomes oGrant rotated left by 1 (MSB wraps to bit 0).
  - In the same cycle, re-arbitrate using the new pointer and the current iRequest, masking off the just-released channel only if another channel is requesting:
    - if the result is non-zero and iEnable=1, load the new grant on that edge (back-to-back, no bubble; oValid stays 1);
    - else clear oGrant and oValid and go to IDLE.
- Fairness:
  - A continuously requesting channel waits at most NUM_CH-1 grants.
  - A single requester may be re-granted immediately after its own release.
- Pointer:
  - Updates only on release, never in IDLE.
  - Always exactly one-hot.
- oData: mux of iData by oGrant; zero when oGrant=0.
- iRelease in IDLE is ignored.
- iEnable falling while GRANTED: the grant persists; on release the arbiter goes to IDLE.
- Reset asserted mid-grant: outputs clear immediately, the pointer returns to channel 0, and no release is required afterwards.
- Invariants checked in simulation:
  - oGrant is zero or one-hot;
  - oValid == |oGrant;
  - oGrantIndex matches oGrant whenever oValid=1.

Test Plan:
- Reset, then iRequest=4'b1111, iRelease pulsed one cycle every 3 cycles -> grant sequence 0,1,2,3,0; oValid held high throughout, no bubble between grants.
- iRequest=4'b0100 with iData ch2=32'hDEADBEEF -> one cycle later oGrant=4'b0100, oGrantIndex=2, oData=32'hDEADBEEF. Then drop iRequest without release -> grant held. Then release -> oValid=0 next cycle.
- Pointer at ch3 (after granting ch2), iRequest=4'b0011 -> next grant is ch0 (wrap-around), not ch1.
- Single requester ch1 continuously requesting with repeated releases -> re-granted ch1 each time, zero idle cycles.
- iEnable=0 with iRequest=4'b1000 -> no grant for 5 cycles. iEnable=1 -> grant ch3 on the following edge.
- Async Reset pulse mid-cycle while ch2 is granted -> oGrant, oValid and oData zero before the next clock edge. After reset with iRequest=4'b1111 -> ch0 granted first.
